// File: rtl/game_link_pkg.sv
// -----------------------------------------------------------------------------
// game_link_pkg
// Shared definitions for the board-to-board game link. The transmitter
// (game_msg_tx) and the opponent-side receiver both import this package, so the
// message codes below are the wire contract between the two boards.
//   MSG_START / MSG_SCORE : first byte of each message type
//   msg_type_e            : which message is being sequenced
//   tx_state_e            : bit-level state of the UART serializer
//   cnt_width()           : width of a counter that spans 0..n-1
// -----------------------------------------------------------------------------
package game_link_pkg;

    localparam logic [7:0] MSG_START = 8'h53;
    localparam logic [7:0] MSG_SCORE = 8'h43;

    typedef enum logic {
        MSG_T_START = 1'b0,
        MSG_T_SCORE = 1'b1
    } msg_type_e;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_START_BIT = 2'd1,
        TX_DATA      = 2'd2,
        TX_STOP      = 2'd3
    } tx_state_e;

    // Bits needed to hold values 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/game_msg_tx_uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// Single-byte 8N1 UART serializer, LSB first, every bit DIV clocks long.
// A byte is accepted when valid_i && ready_o. ready_o is high in idle and on
// the final clock of the stop bit, so a byte offered at that moment follows
// the stop bit with no idle gap (back-to-back frames).
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset (line returns high at once)
//   valid_i  in   byte offered
//   data_i   in   8  byte to send
//   ready_o  out  byte will be taken this cycle if valid_i
//   tx_o     out  serial line, idle high (registered)
// -----------------------------------------------------------------------------
module uart_tx_byte
    import game_link_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       tx_o
);

    localparam int             BW     = cnt_width(DIV);
    localparam logic [BW-1:0]  RELOAD = BW'(DIV - 1);

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic bit_end;
    assign bit_end = (baud_q == '0);

    assign ready_o = (state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_end);
    assign tx_o    = tx_q;

    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? '0 : baud_q - 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;

        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (valid_i) begin
                    state_d = TX_START_BIT;
                    baud_d  = RELOAD;
                    shift_d = data_i;
                    tx_d    = 1'b0;
                end
            end
            TX_START_BIT: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                    baud_d  = RELOAD;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    baud_d = RELOAD;
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // shift_q[0] is the bit currently on the line
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (valid_i) begin
                        state_d = TX_START_BIT;
                        baud_d  = RELOAD;
                        shift_d = data_i;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = TX_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/game_msg_tx.sv
// -----------------------------------------------------------------------------
// game_msg_tx
// Sends local game events (start request, final score) to the opponent board
// over an 8N1 UART link. Holds one pending flag per message type, arbitrates
// START before SCORE, sequences the bytes of each message into uart_tx_byte
// and pulses msg_done when the last stop bit ends.
//   START = 53            SCORE = 43, {0,score}
// Build option GAME_MSG_CHECKSUM_EN: append one byte = XOR of the message's
// previous bytes (START = 53 53, SCORE = 43 s 43^s).
// Ports:
//   pclk        in   sole clock
//   rst         in   asynchronous active-high reset
//   send_start  in   1-cycle pulse, queue START
//   send_score  in   1-cycle pulse, queue SCORE
//   score       in   7  score sampled on the send_score pulse
//   tx          out  UART line, idle high
//   busy        out  message pending or on the line
//   msg_done    out  1-cycle pulse at the end of each message
// -----------------------------------------------------------------------------
module game_msg_tx
    import game_link_pkg::*;
#(
    parameter int CLK_FREQ = 75_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       send_start,
    input  logic       send_score,
    input  logic [6:0] score,
    output logic       tx,
    output logic       busy,
    output logic       msg_done
);

    localparam int DIV = CLK_FREQ / BAUD;

`ifdef GAME_MSG_CHECKSUM_EN
    localparam logic [1:0] START_LEN = 2'd2;
    localparam logic [1:0] SCORE_LEN = 2'd3;
`else
    localparam logic [1:0] START_LEN = 2'd1;
    localparam logic [1:0] SCORE_LEN = 2'd2;
`endif

    // Byte idx of a message. The START checksum is the XOR of one byte, i.e.
    // the header itself, so every START byte is MSG_START.
    function automatic logic [7:0] msg_byte(input msg_type_e t,
                                            input logic [6:0] s,
                                            input logic [1:0] idx);
        logic [7:0] b;
        if (t == MSG_T_START) begin
            b = MSG_START;
        end else begin
            case (idx)
                2'd0:    b = MSG_SCORE;
                2'd1:    b = {1'b0, s};
                default: b = MSG_SCORE ^ {1'b0, s};
            endcase
        end
        return b;
    endfunction

    function automatic logic [1:0] msg_len(input msg_type_e t);
        return (t == MSG_T_START) ? START_LEN : SCORE_LEN;
    endfunction

    logic       start_pend_q, start_pend_d;
    logic       score_pend_q, score_pend_d;
    logic [6:0] hold_q, hold_d;      // latest requested score, not yet on the line
    logic [6:0] val_q, val_d;        // score frozen for the message in flight
    logic       active_q, active_d;
    msg_type_e  type_q, type_d;
    logic [1:0] idx_q, idx_d;        // index of the next byte to hand over
    logic       done_q, done_d;

    logic       ser_valid;
    logic [7:0] ser_data;
    logic       ser_ready;
    logic       ser_tx;

    always_comb begin
        start_pend_d = start_pend_q | send_start;
        score_pend_d = score_pend_q | send_score;
        hold_d       = send_score ? score : hold_q;
        val_d        = val_q;
        active_d     = active_q;
        type_d       = type_q;
        idx_d        = idx_q;
        done_d       = 1'b0;
        ser_valid    = 1'b0;
        ser_data     = msg_byte(type_q, val_q, idx_q);

        if (!active_q) begin
            // Serializer is idle whenever no message is active, so the first
            // byte is accepted immediately and the line drops next edge.
            if (start_pend_q || send_start) begin
                start_pend_d = 1'b0;
                type_d       = MSG_T_START;
                active_d     = 1'b1;
                idx_d        = 2'd1;
                ser_valid    = 1'b1;
                ser_data     = MSG_START;
            end else if (score_pend_q || send_score) begin
                score_pend_d = 1'b0;
                val_d        = send_score ? score : hold_q;
                type_d       = MSG_T_SCORE;
                active_d     = 1'b1;
                idx_d        = 2'd1;
                ser_valid    = 1'b1;
                ser_data     = MSG_SCORE;
            end
        end else if (ser_ready) begin
            // Last clock of a stop bit: either chain the next byte or finish.
            // Finishing drops to idle for at least one cycle before any
            // further message starts.
            if (idx_q == msg_len(type_q)) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end else begin
                ser_valid = 1'b1;
                idx_d     = idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            start_pend_q <= 1'b0;
            score_pend_q <= 1'b0;
            hold_q       <= 7'd0;
            val_q        <= 7'd0;
            active_q     <= 1'b0;
            type_q       <= MSG_T_START;
            idx_q        <= 2'd0;
            done_q       <= 1'b0;
        end else begin
            start_pend_q <= start_pend_d;
            score_pend_q <= score_pend_d;
            hold_q       <= hold_d;
            val_q        <= val_d;
            active_q     <= active_d;
            type_q       <= type_d;
            idx_q        <= idx_d;
            done_q       <= done_d;
        end
    end

    uart_tx_byte #(
        .DIV (DIV)
    ) u_ser (
        .clk     (pclk),
        .rst     (rst),
        .valid_i (ser_valid),
        .data_i  (ser_data),
        .ready_o (ser_ready),
        .tx_o    (ser_tx)
    );

    assign tx       = ser_tx;
    assign busy     = start_pend_q | score_pend_q | active_q;
    assign msg_done = done_q;

endmodule

// File: tb/tb_game_msg_tx.sv
// -----------------------------------------------------------------------------
// tb_game_msg_tx
// Drives game_msg_tx (DIV = 10) with directed scenarios and random pulses and
// compares tx, busy and msg_done every cycle against a message-level model:
// the model tracks pending requests and, for the message in flight, its start
// edge and byte list; the expected line level is derived from the offset into
// the message (10 bits of DIV clocks per byte).
// -----------------------------------------------------------------------------
module tb_game_msg_tx;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int FRAME_T  = 10 * DIV;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       send_start = 1'b0;
    logic       send_score = 1'b0;
    logic [6:0] score = 7'd0;
    logic       tx;
    logic       busy;
    logic       msg_done;

    game_msg_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .send_start (send_start),
        .send_score (send_score),
        .score      (score),
        .tx         (tx),
        .busy       (busy),
        .msg_done   (msg_done)
    );

    always #5 pclk = ~pclk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int         cyc = 0;          // index of the last rising edge
    bit         m_ps = 0;         // START pending
    bit         m_pc = 0;         // SCORE pending
    logic [6:0] m_hold = 7'd0;    // latest requested score
    bit         m_have = 0;       // a message has been launched since reset
    int         m_start = 0;      // edge on which its start bit began
    int         m_len = 0;        // its length in clocks
    int         m_free = 0;       // first edge on which a new message may launch
    logic [7:0] m_b[0:2];
    int         m_nb = 0;

    task automatic load_msg(input logic [7:0] b0, input logic [7:0] b1, input int n);
        logic [7:0] cs;
        m_b[0] = b0;
        m_b[1] = b1;
        m_b[2] = 8'h00;
        m_nb   = n;
`ifdef GAME_MSG_CHECKSUM_EN
        cs = 8'h00;
        for (int i = 0; i < n; i++) cs = cs ^ m_b[i];
        m_b[n] = cs;
        m_nb   = n + 1;
`else
        cs = 8'h00;
`endif
        m_have  = 1;
        m_start = cyc;
        m_len   = m_nb * FRAME_T;
        m_free  = cyc + m_len + 1;
    endtask

    task automatic model_step(input bit s, input bit c, input logic [6:0] v, input bit r);
        bit sreq;
        bit creq;
        cyc++;
        if (r) begin
            m_ps = 0; m_pc = 0; m_hold = 7'd0; m_have = 0; m_free = 0;
            return;
        end
        sreq = m_ps || s;
        creq = m_pc || c;
        if (c) m_hold = v;
        if (s) m_ps = 1;
        if (c) m_pc = 1;
        if (cyc >= m_free && sreq) begin
            m_ps = 0;
            load_msg(8'h53, 8'h00, 1);
        end else if (cyc >= m_free && creq) begin
            m_pc = 0;
            load_msg(8'h43, {1'b0, m_hold}, 2);
        end
    endtask

    function automatic logic exp_tx();
        int off, bi, bt;
        if (!m_have) return 1'b1;
        off = cyc - m_start;
        if (off < 0 || off >= m_len) return 1'b1;
        bi = off / FRAME_T;
        bt = (off % FRAME_T) / DIV;
        if (bt == 0) return 1'b0;
        if (bt == 9) return 1'b1;
        return m_b[bi][bt-1];
    endfunction

    function automatic logic exp_busy();
        return m_ps || m_pc || (m_have && cyc < m_start + m_len);
    endfunction

    function automatic logic exp_done();
        return m_have && (cyc == m_start + m_len);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick(input bit s, input bit c, input logic [6:0] v);
        send_start = s;
        send_score = c;
        score      = v;
        @(posedge pclk);
        model_step(s, c, v, rst);
        @(negedge pclk);
        chk("tx", tx, exp_tx());
        chk("busy", busy, exp_busy());
        chk("msg_done", msg_done, exp_done());
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 7'($urandom));
    endtask

    task automatic wait_idle(input int max_cyc);
        int k;
        k = 0;
        while (busy && k < max_cyc) begin
            idle(1);
            k++;
        end
        chk("idle_reached", busy, 1'b0);
        idle(2);
    endtask

    initial begin
        @(negedge pclk);
        rst = 1'b1;
        repeat (3) tick(1'b0, 1'b0, 7'd0);
        rst = 1'b0;

        // quiet after reset
        idle(50);

        // single START
        tick(1'b1, 1'b0, 7'd0);
        wait_idle(300);

        // SCORE 42
        tick(1'b0, 1'b1, 7'd42);
        wait_idle(500);

        // both in the same cycle
        tick(1'b1, 1'b1, 7'd5);
        wait_idle(900);

        // score overwritten while waiting behind START
        tick(1'b1, 1'b0, 7'd0);
        idle(20);
        tick(1'b0, 1'b1, 7'd3);
        idle(20);
        tick(1'b0, 1'b1, 7'd9);
        wait_idle(900);

        // new score request while SCORE header already on the line
        tick(1'b0, 1'b1, 7'h7F);
        idle(40);
        tick(1'b0, 1'b1, 7'h15);
        wait_idle(1200);

        // asynchronous reset in the middle of a data bit of 0x43
        tick(1'b0, 1'b1, 7'h11);
        idle(35);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_tx", tx, 1'b1);
        chk("rst_async_busy", busy, 1'b0);
        chk("rst_async_done", msg_done, 1'b0);
        tick(1'b0, 1'b0, 7'd0);
        tick(1'b0, 1'b0, 7'd0);
        rst = 1'b0;
        idle(60);

        // random traffic
        repeat (4000) tick($urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0, 7'($urandom));
        send_start = 1'b0;
        send_score = 1'b0;
        wait_idle(1500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
